mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter: FSM states and access owner.
package mem_arbiter_pkg;

  typedef logic [1:0] state_t;
  typedef logic       owner_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_BUSY_I = 2'd1;
  localparam state_t ST_BUSY_D = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  localparam owner_t OWN_I = 1'b0;
  localparam owner_t OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store traffic onto one single-port memory,
// one access in flight, data-first with a fairness override so fetch is not starved.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              err
);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            last_q, last_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              flushed_q, flushed_d;
  logic              err_q, err_d;

  logic d_pend, i_pend, gnt_d, gnt_i;

  // A fetch being redirected this cycle is not worth starting.
  assign d_pend = d_rd | d_wr;
  assign i_pend = if_req & ~if_flush;
  assign gnt_d  = d_pend & ~(i_pend & (last_q == OWN_D));
  assign gnt_i  = i_pend & ~gnt_d;

  always_comb begin
    // NOTE: every variable gets a default here so no path through the case infers a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    flushed_d  = flushed_q;
    err_d      = err_q | (d_rd & d_wr);

    case (state_q)
      ST_IDLE: begin
        if (gnt_d) begin
          state_d   = ST_BUSY_D;
          owner_d   = OWN_D;
          m_req_d   = 1'b1;
          m_we_d    = d_wr;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          flushed_d = 1'b0;
        end else if (gnt_i) begin
          state_d   = ST_BUSY_I;
          owner_d   = OWN_I;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr;
          m_wdata_d = '0;
          flushed_d = 1'b0;
        end
      end
      ST_BUSY_I: begin
        // A redirected fetch still finishes on the memory side; its data is dropped.
        if (if_flush) flushed_d = 1'b1;
        if (m_ack) begin
          state_d = ST_RESP;
          m_req_d = 1'b0;
          if (!(flushed_q | if_flush)) if_rdata_d = m_rdata;
        end
      end
      ST_BUSY_D: begin
        if (m_ack) begin
          state_d = ST_RESP;
          m_req_d = 1'b0;
          if (!m_we_q) d_rdata_d = m_rdata;
        end
      end
      default: begin
        state_d = ST_IDLE;
        last_d  = owner_q;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_I;
      last_q     <= OWN_I;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      flushed_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      flushed_q  <= flushed_d;
      err_q      <= err_d;
    end
  end

  assign if_ready  = (state_q == ST_RESP) & (owner_q == OWN_I) & ~flushed_q & ~if_flush;
  assign d_ready   = (state_q == ST_RESP) & (owner_q == OWN_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign err       = err_q;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_pend & ~d_ready;

endmodule
